project_switch_ctrl: RTL
========================

# project_switch_ctrl

Control stage directly upstream of the two-project wrapper: it produces the wrapper's `ena` (project select) and `rst_n` (project reset) from a raw, asynchronous select pin. A switch runs as a fixed sequence. First the I/O is quiesced, then the select is swapped, then the newly selected project is held in reset. This keeps both projects from fighting over the pads and keeps the new project from starting out of a half-reset state. A status output tells the pad logic when output enables must be forced off.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, 16, consecutive stable synchronized samples needed before a select change is accepted (≥1)
- `QUIET_CYCLES`, 4, cycles the I/O is quiesced before the select swap (≥1)
- `RESET_HOLD`, 8, cycles the project reset is held asserted after a swap or power-on (≥1)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, synchronous, active-low
- `sel_req`  in  1  raw select pin, asynchronous; 0 = PPWM, 1 = SDR
- `restart_req`  in  1  synchronous single-cycle pulse requesting a reset of the current project
- `ena`  out  1  project select to the wrapper; 0 = PPWM, 1 = SDR
- `proj_rst_n`  out  1  project reset to the wrapper, active-low
- `io_quiet`  out  1  1 = downstream must force `uio_oe` to 0 and `uo_out` to 0
- `busy`  out  1  1 while the FSM is not in RUN

## Operation

- All outputs are registered.
- Reset values: `ena`=0, `proj_rst_n`=0, `io_quiet`=1, `busy`=1. FSM resets to HOLD with its counter at 0; `sel_stable`=0.
- Select filter:
  - `sel_req` passes through a 2-flop synchronizer.
  - `sel_stable` updates only after the synchronized value differs from `sel_stable` for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any sample equal to `sel_stable` clears the debounce counter.
- FSM states:
  - **HOLD**:
    - `proj_rst_n`=0, `io_quiet`=1.
    - The counter counts `RESET_HOLD` cycles, then the FSM goes to RUN with `proj_rst_n`=1 and `io_quiet`=0.
  - **RUN**:
    - If `sel_stable` ≠ `ena`, go to QUIET with `target`=`sel_stable` and `io_quiet`=1.
    - Otherwise, if `restart_req`=1, go to QUIET with `target`=`ena`.
  - **QUIET**:
    - `proj_rst_n`=1, so the old project keeps running with its outputs gated.
    - After `QUIET_CYCLES` cycles: `ena`←`target`, `proj_rst_n`←0, go to HOLD.
- `target` is latched on entry to QUIET, so a switch commits once started. If `sel_stable` changes during QUIET or HOLD, it is re-evaluated in RUN and starts a new switch.
- `restart_req` is ignored outside RUN.
- A select change and `restart_req` in the same RUN cycle: the switch wins and the restart is absorbed into it.
- `ena` changes only on the QUIET→HOLD edge. `proj_rst_n` is always 0 on that edge and on the cycle `ena` first shows its new value.

## Timing

- Edges are counted from the first rising edge with `rst_n`=1. After reset release, HOLD lasts `RESET_HOLD` cycles, so `proj_rst_n` and `io_quiet` change on edge `RESET_HOLD`.
- Pin-to-accept latency: `sel_stable` flips 2 + `DEBOUNCE_CYCLES` cycles after a clean `sel_req` edge.
- Full switch sequence:
  - `io_quiet` rises 1 cycle after `sel_stable` flips.
  - `ena` toggles and `proj_rst_n` falls `QUIET_CYCLES` cycles later.
  - `proj_rst_n` rises and `io_quiet` falls `RESET_HOLD` cycles after that.
- Restart: `io_quiet` rises on the edge after the `restart_req` pulse. Then `QUIET_CYCLES` of quiet, then `RESET_HOLD` of reset; `ena` is unchanged.
- `rst_n` low mid-sequence, in any state:
  - All outputs take their reset values on that edge, including `ena`=0.
  - The synchronizer and debounce state clear.
- Counters are `$clog2(max+1)` bits wide. There is no wrap: each counter saturates at its terminal count and clears on state change.

## Structure

- Package `project_switch_pkg`: the state enum `sw_state_t` {HOLD, RUN, QUIET} and the default constants for the three parameters.
- Sub-module `sel_debounce`: the 2-flop synchronizer plus debounce counter. Parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst_n`, `din`, `dout`.
- Top level: the FSM, the shared cycle counter, `target`, and the output registers.

## Test plan

All scenarios use the defaults (16/4/8).

- **Power-on**: `rst_n`=0 for 5 cycles, then 1, with `sel_req`=0. Expect `ena`=0; `proj_rst_n`=0, `io_quiet`=1, `busy`=1 through edge 7; `proj_rst_n`=1, `io_quiet`=0, `busy`=0 from edge 8.
- **Switch 0→1**: in RUN, set `sel_req`=1 at cycle t. Expect `sel_stable`=1 at t+18, `io_quiet`=1 at t+19, `ena`=1 and `proj_rst_n`=0 at t+23, `proj_rst_n`=1 and `io_quiet`=0 at t+31.
- **Glitch reject**: pulse `sel_req` high for 10 cycles, then low. Expect `ena`, `io_quiet` and `busy` unchanged.
- **Restart**: one-cycle `restart_req` in RUN at t. Expect `io_quiet`=1 at t+1, `proj_rst_n`=0 at t+5, release at t+13, `ena` constant.
- **Reversal mid-switch**: return `sel_req` to 0 during QUIET after an accepted 0→1. Expect the 0→1 switch to complete, then a second full sequence back to `ena`=0.
- **Reset mid-HOLD**: pull `rst_n` low for 1 cycle at HOLD count 3 during a switch to `ena`=1. Expect `ena`=0, `proj_rst_n`=0, `io_quiet`=1 on the next edge, then a fresh 8-cycle HOLD.

Source files
------------

// File: rtl/project_switch_pkg.sv
// Shared types and default timing constants for the project switch controller.
package project_switch_pkg;

    typedef enum logic [1:0] {
        StHold,
        StRun,
        StQuiet
    } sw_state_t;

    localparam int unsigned DefaultDebounceCycles = 16;
    localparam int unsigned DefaultQuietCycles    = 4;
    localparam int unsigned DefaultResetHold      = 8;

endpackage

// File: rtl/sel_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debounce filter.
module sel_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CntLast) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/project_switch_ctrl.sv
// Sequences project select changes: quiesce I/O, swap ena, then hold the new
// project in reset before letting it run.
module project_switch_ctrl
    import project_switch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned QUIET_CYCLES    = DefaultQuietCycles,
    parameter int unsigned RESET_HOLD      = DefaultResetHold
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sel_req,
    input  logic restart_req,
    output logic ena,
    output logic proj_rst_n,
    output logic io_quiet,
    output logic busy
);

    localparam int unsigned MaxCount  = (QUIET_CYCLES > RESET_HOLD) ? QUIET_CYCLES : RESET_HOLD;
    localparam int unsigned CntW      = $clog2(MaxCount + 1);
    localparam logic [CntW-1:0] QuietLast = CntW'(QUIET_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(RESET_HOLD - 1);

    logic            sel_stable;
    sw_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            target_q, target_d;
    logic            ena_q, ena_d;
    logic            proj_rst_n_q, proj_rst_n_d;
    logic            io_quiet_q, io_quiet_d;
    logic            busy_q, busy_d;

    sel_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sel_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sel_req),
        .dout (sel_stable)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StHold;
            cnt_q        <= '0;
            target_q     <= 1'b0;
            ena_q        <= 1'b0;
            proj_rst_n_q <= 1'b0;
            io_quiet_q   <= 1'b1;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            ena_q        <= ena_d;
            proj_rst_n_q <= proj_rst_n_d;
            io_quiet_q   <= io_quiet_d;
            busy_q       <= busy_d;
        end
    end

    // A pending select change takes priority over restart and absorbs it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        unique case (state_q)
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (sel_stable != ena_q) begin
                    state_d  = StQuiet;
                    target_d = sel_stable;
                    cnt_d    = '0;
                end else if (restart_req) begin
                    state_d  = StQuiet;
                    target_d = ena_q;
                    cnt_d    = '0;
                end
            end
            StQuiet: begin
                if (cnt_q == QuietLast) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StHold;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ena_d = ena_q;
        if (state_q == StQuiet && state_d == StHold) begin
            ena_d = target_q;
        end
        proj_rst_n_d = (state_d != StHold);
        io_quiet_d   = (state_d != StRun);
        busy_d       = (state_d != StRun);
    end

    assign ena        = ena_q;
    assign proj_rst_n = proj_rst_n_q;
    assign io_quiet   = io_quiet_q;
    assign busy       = busy_q;

endmodule
